// File: rtl/fifo_rd_unpack_64to32.sv
// Purpose: drain a FWFT 64-bit FIFO into a framed 32-bit valid/ready stream, high half first.
// Latency: FIFO head present with holding register empty -> o_valid one cycle later; one half-word per cycle sustained.
// Backpressure: i_ready low holds o_data and flags stable; the next word is popped only on the final-half accept.
module fifo_rd_unpack_64to32 #(
    parameter int LEN_W  = 16,
    parameter int PCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [63:0]       i_fifo_data,
    input  logic              i_fifo_empty,
    output logic              o_fifo_rd_en,
    output logic              o_valid,
    output logic [31:0]       o_data,
    output logic              o_first,
    output logic              o_last,
    input  logic              i_ready,
    output logic              o_busy,
    output logic [PCNT_W-1:0] o_pkt_cnt
);

    typedef enum logic {
        ST_HDR  = 1'b0,
        ST_BODY = 1'b1
    } state_t;

    state_t             state;
    logic [63:0]        hold;
    logic               hold_vld;
    logic               hs;
    logic               tag_first;
    logic               tag_last;
    logic [LEN_W-1:0]   rem;
    logic               busy;
    logic [PCNT_W-1:0]  pkt_cnt;

    logic               acc;
    logic               pop;
    logic               last_acc;
    logic [LEN_W-1:0]   hdr_len;

    // Length field sits at the top of the header word.
    assign hdr_len  = i_fifo_data[63 -: LEN_W];

    assign acc      = hold_vld & i_ready;
    // Refill only when the holding register is empty or its final half leaves this cycle;
    // reset gating keeps the FIFO untouched while rst_n is low.
    assign pop      = rst_n & ~i_fifo_empty & (~hold_vld | (acc & hs));
    assign last_acc = acc & tag_last & hs;

    assign o_fifo_rd_en = pop;
    assign o_valid      = hold_vld;
    assign o_data       = hs ? hold[31:0] : hold[63:32];
    assign o_first      = tag_first & ~hs;
    assign o_last       = tag_last & hs;
    assign o_busy       = busy;
    assign o_pkt_cnt    = pkt_cnt;

    // Holding register, half select and packet-framing FSM; the FSM only advances on a pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold      <= '0;
            hold_vld  <= 1'b0;
            hs        <= 1'b0;
            tag_first <= 1'b0;
            tag_last  <= 1'b0;
            rem       <= '0;
            state     <= ST_HDR;
        end else if (pop) begin
            hold     <= i_fifo_data;
            hold_vld <= 1'b1;
            hs       <= 1'b0;
            case (state)
                ST_HDR: begin
                    rem       <= hdr_len;
                    tag_first <= 1'b1;
                    if (hdr_len != '0) begin
                        tag_last <= 1'b0;
                        state    <= ST_BODY;
                    end else begin
                        tag_last <= 1'b1;
                        state    <= ST_HDR;
                    end
                end
                ST_BODY: begin
                    tag_first <= 1'b0;
                    rem       <= rem - LEN_W'(1);
                    if (rem == LEN_W'(1)) begin
                        tag_last <= 1'b1;
                        state    <= ST_HDR;
                    end else begin
                        tag_last <= 1'b0;
                    end
                end
                default: state <= ST_HDR;
            endcase
        end else if (acc) begin
            if (hs) begin
                // Word fully sent and nothing to refill with: free it and drop its tags.
                hs        <= 1'b0;
                hold_vld  <= 1'b0;
                tag_first <= 1'b0;
                tag_last  <= 1'b0;
            end else begin
                hs <= 1'b1;
            end
        end
    end

    // Packet bookkeeping: busy spans header pop to last accept; counter counts completed packets.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            pkt_cnt <= '0;
        end else begin
            if (last_acc) begin
                pkt_cnt <= pkt_cnt + PCNT_W'(1);
            end
            // A header popped in the same cycle as the previous last accept keeps busy high.
            if (pop && (state == ST_HDR)) begin
                busy <= 1'b1;
            end else if (last_acc) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_unpack_64to32.sv
// Purpose: randomized and directed stimulus for fifo_rd_unpack_64to32 with a packet-level scoreboard.
// Latency: expected half-words are queued when packets are written to the modelled FIFO.
// Backpressure: i_ready and FIFO emptiness are driven per cycle; a monitor checks every negedge.
module tb_fifo_rd_unpack_64to32;

    localparam int LEN_W  = 16;
    localparam int PCNT_W = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [63:0]       i_fifo_data;
    logic              i_fifo_empty;
    logic              o_fifo_rd_en;
    logic              o_valid;
    logic [31:0]       o_data;
    logic              o_first;
    logic              o_last;
    logic              i_ready;
    logic              o_busy;
    logic [PCNT_W-1:0] o_pkt_cnt;

    typedef struct {
        logic [63:0] w;
        bit          is_hdr;
    } fword_t;

    typedef struct {
        logic [31:0] d;
        bit          first;
        bit          last;
        bit          low;
    } half_t;

    fword_t            fifo_q[$];
    half_t             exp_q[$];
    int                checks    = 0;
    int                errors    = 0;
    int                hdr_pops  = 0;
    int                pkts_done = 0;
    int                acc_total = 0;
    logic [PCNT_W-1:0] exp_cnt   = '0;
    bit                force_empty = 1'b0;
    bit                chk_zero    = 1'b0;
    bit                last_rd;
    bit                last_vld;
    bit                stall_prev = 1'b0;
    logic [31:0]       prev_d;
    bit                prev_f;
    bit                prev_l;
    bit                exp_rd;
    half_t             e;

    fifo_rd_unpack_64to32 #(
        .LEN_W  (LEN_W),
        .PCNT_W (PCNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_fifo_data  (i_fifo_data),
        .i_fifo_empty (i_fifo_empty),
        .o_fifo_rd_en (o_fifo_rd_en),
        .o_valid      (o_valid),
        .o_data       (o_data),
        .o_first      (o_first),
        .o_last       (o_last),
        .i_ready      (i_ready),
        .o_busy       (o_busy),
        .o_pkt_cnt    (o_pkt_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every 64-bit word is two beats, high half first; the header's high half is first,
    // the low half of the packet's final word is last.
    task automatic add_halves(input logic [63:0] w, input bit first, input bit last);
        exp_q.push_back('{w[63:32], first, 1'b0, 1'b0});
        exp_q.push_back('{w[31:0], 1'b0, last, 1'b1});
    endtask

    task automatic push_hdr(input logic [63:0] w);
        fifo_q.push_back('{w, 1'b1});
        add_halves(w, 1'b1, w[63:48] == 16'd0);
    endtask

    task automatic push_pay(input logic [63:0] w, input bit last);
        fifo_q.push_back('{w, 1'b0});
        add_halves(w, 1'b0, last);
    endtask

    task automatic push_rand_pkt(input int len);
        logic [63:0] r;
        r = {$urandom, $urandom};
        push_hdr({16'(len), r[47:0]});
        for (int i = 0; i < len; i++) begin
            push_pay({$urandom, $urandom}, i == len - 1);
        end
    endtask

    task automatic drive_fifo();
        i_fifo_empty = force_empty || (fifo_q.size() == 0);
        if (fifo_q.size() > 0) i_fifo_data = fifo_q[0].w;
        else                   i_fifo_data = {$urandom, $urandom};
    endtask

    // One clock: present FIFO head, sample at negedge, apply the pop just after posedge.
    task automatic tick();
        bit     pop;
        fword_t fw;
        drive_fifo();
        @(negedge clk);
        pop      = o_fifo_rd_en;
        last_rd  = pop;
        last_vld = o_valid;
        if (chk_zero) begin
            check("rst_out_zero", {o_valid, o_first, o_last, o_busy, 30'(o_pkt_cnt)}, 64'd0);
            check("rst_data_zero", o_data, 64'd0);
        end
        @(posedge clk);
        #1;
        if (pop && fifo_q.size() > 0) begin
            fw = fifo_q.pop_front();
            if (fw.is_hdr) hdr_pops++;
        end
    endtask

    task automatic window(input int n, output logic [15:0] vv, output logic [15:0] rr);
        vv = '0;
        rr = '0;
        for (int i = 0; i < n; i++) begin
            tick();
            vv[i] = last_vld;
            rr[i] = last_rd;
        end
    endtask

    task automatic drain(input bit rnd);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || fifo_q.size() > 0) && n < 5000) begin
            if (rnd) begin
                i_ready     = ($urandom_range(0, 3) != 0);
                force_empty = ($urandom_range(0, 6) == 0);
            end else begin
                i_ready     = 1'b1;
                force_empty = 1'b0;
            end
            tick();
            n++;
        end
        force_empty = 1'b0;
        i_ready     = 1'b1;
        check("drain_left", exp_q.size(), 64'd0);
        tick();
        tick();
    endtask

    // Monitor: scoreboard compare, packet count, busy, pop rule and stall stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
            check("rst_rd_en", o_fifo_rd_en, 64'd0);
        end else begin
            check("pkt_cnt", o_pkt_cnt, exp_cnt);
            check("busy", o_busy, hdr_pops != pkts_done);
            exp_rd = !i_fifo_empty && (!o_valid || (i_ready && exp_q.size() > 0 && exp_q[0].low));
            check("rd_en", o_fifo_rd_en, exp_rd);
            if (stall_prev) begin
                check("stall_hold", {o_valid, o_first, o_last, o_data}, {1'b1, prev_f, prev_l, prev_d});
            end
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", o_valid, 64'd0);
                end else begin
                    e = exp_q[0];
                    check("half", {o_first, o_last, o_data}, {e.first, e.last, e.d});
                    if (i_ready) begin
                        e = exp_q.pop_front();
                        acc_total++;
                        if (e.last) begin
                            pkts_done++;
                            exp_cnt++;
                        end
                    end
                end
            end
            stall_prev = o_valid && !i_ready;
            prev_d     = o_data;
            prev_f     = o_first;
            prev_l     = o_last;
        end
    end

    initial begin
        logic [15:0] vv;
        logic [15:0] rr;
        int          a0;
        i_ready      = 1'b0;
        i_fifo_empty = 1'b1;
        i_fifo_data  = '0;
        rst_n        = 1'b0;
        tick();
        tick();
        rst_n    = 1'b1;
        chk_zero = 1'b1;
        tick();
        chk_zero = 1'b0;

        // Single-word packet.
        i_ready = 1'b1;
        push_hdr(64'h0000_1111_2222_3333);
        repeat (4) tick();
        check("t1_pkt_cnt", o_pkt_cnt, 64'd1);
        check("t1_busy", o_busy, 64'd0);

        // LEN=2 preloaded, full rate: no gaps, pops on cycles 0, 2, 4.
        push_hdr(64'h0002_0000_0000_0000);
        push_pay(64'hAAAA_BBBB_CCCC_DDDD, 1'b0);
        push_pay(64'h1234_5678_9ABC_DEF0, 1'b1);
        window(8, vv, rr);
        check("t2_valid_pattern", vv, 64'h7E);
        check("t2_rd_pattern", rr, 64'h15);

        // Same packet with ready toggling.
        push_hdr(64'h0002_0000_0000_0000);
        push_pay(64'hAAAA_BBBB_CCCC_DDDD, 1'b0);
        push_pay(64'h1234_5678_9ABC_DEF0, 1'b1);
        for (int i = 0; i < 14; i++) begin
            i_ready = (i % 2 == 0);
            tick();
        end
        drain(1'b0);

        // FIFO empty mid-packet for five cycles.
        push_rand_pkt(3);
        repeat (3) tick();
        force_empty = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (i >= 2) begin
                check("t4_gap_valid", last_vld, 64'd0);
                check("t4_gap_rd", last_rd, 64'd0);
                check("t4_gap_busy", o_busy, 64'd1);
            end
        end
        force_empty = 1'b0;
        drain(1'b0);

        // Back-to-back LEN=1 then LEN=0.
        push_hdr(64'h0001_0000_0000_0001);
        push_pay(64'h0BAD_F00D_CAFE_BEEF, 1'b1);
        push_hdr(64'h0000_0000_0000_0002);
        window(8, vv, rr);
        check("t5_valid_pattern", vv, 64'h7E);
        check("t5_rd_pattern", rr, 64'h15);

        // Reset after the second half-word of a LEN=3 packet.
        push_rand_pkt(3);
        a0 = acc_total;
        for (int i = 0; i < 20 && acc_total < a0 + 2; i++) tick();
        check("t6_two_halves", acc_total - a0, 64'd2);
        rst_n = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        hdr_pops  = 0;
        pkts_done = 0;
        exp_cnt   = '0;
        push_hdr(64'h0001_5555_6666_7777);
        push_pay({$urandom, $urandom}, 1'b1);
        tick();
        rst_n    = 1'b1;
        chk_zero = 1'b1;
        tick();
        chk_zero = 1'b0;
        drain(1'b0);

        // Random soak; the 2-bit packet counter wraps many times.
        for (int k = 0; k < 40; k++) begin
            push_rand_pkt($urandom_range(0, 6));
            if (k == 20) push_rand_pkt(300);
        end
        drain(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
